// File: rtl/condicionador_botoes_pkg.sv
// Shared types and constants for the push-button conditioner.
// Channel state encoding and button index map (0 = conta, 1 = pausa, 2 = para).
package condicionador_botoes_pkg;

    typedef enum logic [1:0] {
        SOLTO          = 2'd0,
        CONFIRMA_PRESS = 2'd1,
        PRESSIONADO    = 2'd2,
        CONFIRMA_SOLTA = 2'd3
    } estado_canal_t;

    localparam int unsigned BOTAO_CONTA = 0;
    localparam int unsigned BOTAO_PAUSA = 1;
    localparam int unsigned BOTAO_PARA  = 2;

    // Debounced level is "pressed" while pressed or while a release is being confirmed.
    function automatic logic nivel_do_estado(estado_canal_t estado);
        return (estado == PRESSIONADO) || (estado == CONFIRMA_SOLTA);
    endfunction

endpackage

// File: rtl/condicionador_botoes_debounce_canal.sv
// One button channel: 2-FF synchronizer, stability counter and press/release FSM.
// Emits a one-cycle registered pulse per accepted press and a registered debounced level.
module debounce_canal
    import condicionador_botoes_pkg::*;
#(
    parameter int unsigned TEMPO_DEBOUNCE = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic botao_ni,
    output logic pulso_o,
    output logic nivel_o
);

    localparam int unsigned CONT_W = $clog2(TEMPO_DEBOUNCE + 1);
    localparam logic [CONT_W-1:0] CNT_FIM = CONT_W'(TEMPO_DEBOUNCE - 1);
    localparam logic [CONT_W-1:0] CNT_UM  = CONT_W'(1);

    logic              sync1_q, sync2_q;
    logic              s;
    estado_canal_t     estado_q, estado_d;
    logic [CONT_W-1:0] cnt_q, cnt_d;
    logic              pulso_q, pulso_d;
    logic              nivel_q, nivel_d;

    // Synchronizer resets to "released" so reset never looks like a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= botao_ni;
            sync2_q <= sync1_q;
        end
    end

    assign s = ~sync2_q;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pulso_d  = 1'b0;
        unique case (estado_q)
            SOLTO: begin
                if (s) begin
                    estado_d = CONFIRMA_PRESS;
                    cnt_d    = CNT_UM;
                end
            end
            CONFIRMA_PRESS: begin
                if (!s) begin
                    estado_d = SOLTO;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_FIM) begin
                    estado_d = PRESSIONADO;
                    cnt_d    = '0;
                    pulso_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            PRESSIONADO: begin
                if (!s) begin
                    estado_d = CONFIRMA_SOLTA;
                    cnt_d    = CNT_UM;
                end
            end
            CONFIRMA_SOLTA: begin
                if (s) begin
                    estado_d = PRESSIONADO;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_FIM) begin
                    estado_d = SOLTO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            default: begin
                estado_d = SOLTO;
                cnt_d    = '0;
            end
        endcase
        nivel_d = nivel_do_estado(estado_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            estado_q <= SOLTO;
            cnt_q    <= '0;
            pulso_q  <= 1'b0;
            nivel_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            pulso_q  <= pulso_d;
            nivel_q  <= nivel_d;
        end
    end

    assign pulso_o = pulso_q;
    assign nivel_o = nivel_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Push-button front end: one debounce channel per button feeding the stopwatch FSM.
// Define PULSO_EXCLUSIVO_EN to make pulsos one-hot-or-zero (highest index wins).
module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int unsigned NUM_BOTOES     = 3,
    parameter int unsigned TEMPO_DEBOUNCE = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BOTOES-1:0] botoes_n,
    output logic [NUM_BOTOES-1:0] pulsos,
    output logic [NUM_BOTOES-1:0] nivel
);

    logic [NUM_BOTOES-1:0] pulsos_canal;

    for (genvar gi = 0; gi < NUM_BOTOES; gi++) begin : g_canal
        debounce_canal #(
            .TEMPO_DEBOUNCE(TEMPO_DEBOUNCE)
        ) u_canal (
            .clk_i   (clk),
            .rst_ni  (reset),
            .botao_ni(botoes_n[gi]),
            .pulso_o (pulsos_canal[gi]),
            .nivel_o (nivel[gi])
        );
    end

`ifdef PULSO_EXCLUSIVO_EN
    // Lower-index pulses colliding with a higher one are dropped, not deferred.
    always_comb begin
        logic achou;
        pulsos = '0;
        achou  = 1'b0;
        for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
            if (pulsos_canal[i] && !achou) begin
                pulsos[i] = 1'b1;
                achou     = 1'b1;
            end
        end
    end
`else
    assign pulsos = pulsos_canal;
`endif

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Input-side front end for the stopwatch control FSM. Takes raw, bouncing, active-low push-buttons (conta, pausa, para) from the board.
- Produces clean, clock-synchronous one-cycle press pulses and debounced levels, which drive the state machine's command inputs.
- One independent channel per button: 2-FF synchronizer, debounce counter and per-channel FSM.

Parameters:
- NUM_BOTOES, 3, number of button channels; index 0 = conta, 1 = pausa, 2 = para.
- TEMPO_DEBOUNCE, 1000000, consecutive stable clk cycles required to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
- Derived localparam CONT_W = $clog2(TEMPO_DEBOUNCE+1); not overridable.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- botoes_n  input  NUM_BOTOES  raw buttons; 0 = pressed; asynchronous to clk.
- pulsos  output  NUM_BOTOES  registered; bit i high for exactly one clk cycle per accepted press of button i.
- nivel  output  NUM_BOTOES  registered debounced level; 1 = pressed.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both synchronizer stages load 1 (released).
  - Every channel FSM goes to SOLTO; counters go to 0.
  - pulsos = 0 and nivel = 0.
- Synchronizer: s[i] = inverted output of stage 2. It is valid after the second clk edge that samples the raw pin.
- Per-channel FSM, one transition per clk edge, based on sampled s:
  - SOLTO: s=1 → CONFIRMA_PRESS with cnt=1; otherwise stay.
  - CONFIRMA_PRESS:
    - s=0 → SOLTO, cnt=0.
    - s=1 and cnt=TEMPO_DEBOUNCE-1 → PRESSIONADO, cnt=0, pulsos[i]=1.
    - Otherwise cnt+1.
  - PRESSIONADO: s=0 → CONFIRMA_SOLTA with cnt=1; otherwise stay.
  - CONFIRMA_SOLTA:
    - s=1 → PRESSIONADO, cnt=0, no pulse.
    - s=0 and cnt=TEMPO_DEBOUNCE-1 → SOLTO, cnt=0.
    - Otherwise cnt+1.
- Outputs:
  - nivel[i] = 1 in PRESSIONADO and CONFIRMA_SOLTA; 0 otherwise.
  - pulsos[i] is high only in the cycle immediately after entering PRESSIONADO.
- Latency: raw pin low before edge E0 and held stable → s=1 sampled at E2..E(N+1), with N = TEMPO_DEBOUNCE. pulsos and nivel rise after E(N+1); pulsos falls after E(N+2).
- Bounce: any single-cycle glitch during confirmation restarts the full count. A glitch in PRESSIONADO never produces a second pulse.
- Hold: a held button produces exactly one pulse; there is no auto-repeat.
- Release: no pulse on release.
- Simultaneous presses: channels are fully independent; multiple pulsos bits may be high in the same cycle (see optional feature).
- Reset mid-operation: all in-flight counts are discarded. A button held through reset release is treated as a new press and pulses N+2 edges after reset deasserts.
- Counter saturation cannot occur: cnt never exceeds TEMPO_DEBOUNCE-1.

Optional Feature:
- Macro: PULSO_EXCLUSIVO_EN.
- Defined: pulsos is made one-hot-or-zero by fixed priority, highest index wins (para > pausa > conta). Lower-index pulses in the same cycle are dropped, not delayed. nivel is unaffected.
- Not defined: pulsos is driven directly from the channels, so simultaneous bits are possible.

Decomposition:
- Shared package holds:
  - Channel state enum: SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTA.
  - Button index constants: BOTAO_CONTA=0, BOTAO_PAUSA=1, BOTAO_PARA=2.
- One sub-module, debounce_canal: a single channel containing synchronizer, counter and FSM. It is instantiated NUM_BOTOES times via generate.
- The optional priority logic sits in the top module.

Test Plan (TEMPO_DEBOUNCE=4 unless stated):
- Clean press: botoes_n[0] low before E0, held 20 cycles → pulsos[0] high only in the cycle after E5; nivel[0] rises after E5 and stays 1. No pulse on release; nivel[0] falls 6 edges after the pin returns high.
- Bounce: pin low 2 cycles, high 1 cycle, then low and held → exactly one pulse, 5 edges after the final falling sample plus synchronizer delay. No pulse for the 2-cycle burst.
- Glitch while pressed: in PRESSIONADO, pin high for 1 cycle → nivel stays 1 and no extra pulse. Pin high for 4+ cycles then low again stable → second pulse.
- Reset mid-confirmation: assert reset when cnt=2 → all outputs 0 immediately (asynchronous). Button still held at deassert → pulse after the 6th edge post-reset.
- Simultaneous press of buttons 0 and 2 on the same edge:
  - Without PULSO_EXCLUSIVO_EN → pulsos=3'b101 for one cycle.
  - With PULSO_EXCLUSIVO_EN → pulsos=3'b100.
  - In both cases nivel=3'b101.
- Default parameter smoke test (TEMPO_DEBOUNCE=1000000): stable press → pulse exactly 1000001 edges after first sample.
